// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, bit-serial shifts,
// valid/ready handshake on both request and result sides.
module alu_mc #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   SrcA,
   input  logic [WIDTH-1:0]   SrcB,
   input  logic [2:0]         ALUControl,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   ALUResult,
   output logic               Zero
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SRL = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_SLL = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [SHAMT_W-1:0] cnt;
   logic [SHAMT_W-1:0] cnt_next;
   logic [SHAMT_W-1:0] shamt;
   logic               shift_left;
   logic               shift_left_next;
   logic               is_shift;
   logic               load;
   logic [WIDTH-1:0]   alu_value;
   logic [WIDTH-1:0]   first_step;
   logic [WIDTH-1:0]   step_value;
   logic [WIDTH-1:0]   result_next;

   assign shamt     = SrcB[SHAMT_W-1:0];
   assign is_shift  = (ALUControl == OP_SRL) || (ALUControl == OP_SLL);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_comb begin
      alu_value = '0;
      case (ALUControl)
         OP_ADD:  alu_value = SrcA + SrcB;
         OP_SUB:  alu_value = SrcA - SrcB;
         OP_AND:  alu_value = SrcA & SrcB;
         OP_OR:   alu_value = SrcA | SrcB;
         OP_XOR:  alu_value = SrcA ^ SrcB;
         OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         default: alu_value = '0;
      endcase
   end

   // The first shift step happens at acceptance so a shift by N shows its
   // result N cycles after acceptance, matching the 1-cycle non-shift path.
   assign first_step = (ALUControl == OP_SLL) ? {SrcA[WIDTH-2:0], 1'b0}
                                              : {1'b0, SrcA[WIDTH-1:1]};
   assign step_value = shift_left ? {ALUResult[WIDTH-2:0], 1'b0}
                                  : {1'b0, ALUResult[WIDTH-1:1]};

   always_comb begin
      state_next      = state;
      cnt_next        = cnt;
      shift_left_next = shift_left;
      result_next     = ALUResult;
      load            = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               load = 1'b1;
               if (is_shift) begin
                  shift_left_next = (ALUControl == OP_SLL);
                  if (shamt == '0) begin
                     result_next = SrcA;
                     cnt_next    = '0;
                     state_next  = DONE;
                  end else begin
                     result_next = first_step;
                     cnt_next    = shamt - SHAMT_W'(1);
                     state_next  = (shamt == SHAMT_W'(1)) ? DONE : SHIFT;
                  end
               end else begin
                  result_next = alu_value;
                  cnt_next    = '0;
                  state_next  = DONE;
               end
            end
         end
         SHIFT: begin
            load        = 1'b1;
            result_next = step_value;
            cnt_next    = cnt - SHAMT_W'(1);
            if (cnt == SHAMT_W'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Zero only moves when the result register moves, so it stays 0 after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         shift_left <= 1'b0;
         ALUResult  <= '0;
         Zero       <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         shift_left <= shift_left_next;
         if (load) begin
            ALUResult <= result_next;
            Zero      <= (result_next == '0);
         end
      end
   end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width in bits.
REQ-002 SHALL have parameter: SHAMT_W, 5, shift-amount width; equals log2(WIDTH).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  operation request present.
REQ-006 SHALL have port: in_ready  output  1  block can accept a request.
REQ-007 SHALL have port: SrcA  input  WIDTH  first operand.
REQ-008 SHALL have port: SrcB  input  WIDTH  second operand; SrcB[SHAMT_W-1:0] is the shift amount for shifts.
REQ-009 SHALL have port: ALUControl  input  3  operation code from the ALU decoder.
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port: ALUResult  output  WIDTH  registered result.
REQ-013 SHALL have port: Zero  output  1  registered flag, 1 when ALUResult is all zeros.

Function
REQ-014 SHALL decode ALUControl as: 000 add; 001 sub; 010 and; 011 or; 100 srl; 101 slt; 110 xor; 111 sll.
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge where in_valid & in_ready, capturing SrcA, SrcB, ALUControl; later changes on these inputs SHALL be ignored until the next acceptance.
REQ-017 SHALL, for non-shift ops, register the result at acceptance and enter DONE; out_valid high the cycle after acceptance (latency 1).
REQ-018 SHALL compute add/sub modulo 2^WIDTH, with carry/borrow discarded.
REQ-019 SHALL compute slt as a signed two's-complement compare: result = {WIDTH-1 zeros, (SrcA < SrcB)}.
REQ-020 SHALL, for srl/sll, load SrcA into the result register and the shift amount into a down-counter at acceptance; enter SHIFT if the amount is nonzero, otherwise DONE.
REQ-021 SHALL, in SHIFT, shift the result register by one bit per cycle (srl zero-fills the MSB; sll zero-fills the LSB) and decrement the counter; enter DONE on the cycle the counter reaches 0.
REQ-022 SHALL give shift latency = max(shamt,1) cycles from acceptance to out_valid; shamt 31 takes 31 cycles.
REQ-023 SHALL use only SrcB[SHAMT_W-1:0] as the shift amount; upper SrcB bits are ignored.
REQ-024 SHALL update Zero in the same cycle as ALUResult, from the final result value.
REQ-025 SHALL, in DONE, hold out_valid, ALUResult, and Zero stable until out_valid & out_ready, then return to IDLE on that edge.
REQ-026 SHALL NOT accept a new request in the DONE cycle in which out_ready is sampled; the next acceptance is possible one cycle later, at the earliest.
REQ-027 SHALL keep out_valid low in IDLE and SHIFT; out_ready is a don't-care outside DONE.

Reset
REQ-028 SHALL, when reset is high at a rising edge, set state IDLE, out_valid 0, ALUResult 0, Zero 0, and shift counter 0, regardless of state.
REQ-029 SHALL give reset priority over any handshake in the same cycle; a request presented with reset high is dropped.
REQ-030 SHALL, on reset mid-SHIFT or in DONE, abort the operation with no out_valid pulse; in_ready = 1 the cycle after reset deasserts.

Verification
REQ-031 SHALL verify: add 0x7FFFFFFF+1 and sub 5-5 -> ALUResult 0x80000000 with Zero 0; then ALUResult 0 with Zero 1; each out_valid one cycle after acceptance.
REQ-032 SHALL verify slt: SrcA=0xFFFFFFFF, SrcB=1 -> ALUResult 1; swapped operands -> ALUResult 0.
REQ-033 SHALL verify sll: SrcA=1, SrcB=0x0000003F (shamt 31) -> out_valid 31 cycles after acceptance, ALUResult 0x80000000, in_ready low throughout.
REQ-034 SHALL verify srl with shamt 0 (SrcA=0xA5A5A5A5) -> ALUResult 0xA5A5A5A5 after 1 cycle; srl by 4 -> 0x0A5A5A5A after 4 cycles.
REQ-035 SHALL verify backpressure: out_ready held low 10 cycles in DONE -> out_valid, ALUResult, Zero stable, in_ready 0; operand changes ignored; release -> IDLE next cycle.
REQ-036 SHALL verify reset asserted on the 3rd SHIFT cycle of sll by 8 -> out_valid never asserts, ALUResult 0, in_ready 1 the cycle after reset deasserts.
